// File: rtl/tone_sequencer.sv
// Queued square-wave note player: {note, duration} commands enter a FIFO and
// are played one after another, with an optional silent gap between notes.
module tone_sequencer #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int NUM_OCTAVES = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int DUR_W       = 16,
  parameter int GAP_MS      = 10
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              CMD_VALID,
  output logic                              CMD_READY,
  input  logic [7:0]                        NOTE,
  input  logic [DUR_W-1:0]                  DUR_MS,
  input  logic                              STOP,
  output logic                              SPEAKER,
  output logic                              BUSY,
  output logic                              NOTE_DONE,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   FIFO_COUNT
);

  // Half-period in clocks of semitone s in octave 5, rounded to nearest.
  function automatic int base_half(input int s);
    real f;
    f = 440.0 * (2.0 ** (real'(s + 3) / 12.0));
    return $rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5);
  endfunction

  localparam int BASE [12] = '{base_half(0), base_half(1), base_half(2),
                               base_half(3), base_half(4), base_half(5),
                               base_half(6), base_half(7), base_half(8),
                               base_half(9), base_half(10), base_half(11)};
  localparam int HW   = $clog2(BASE[0] + 1);
  localparam int MS   = CLK_HZ / 1000;
  localparam int PW   = (MS > 1) ? $clog2(MS) : 1;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int MAXN = 12 * NUM_OCTAVES;
  localparam logic [DUR_W-1:0] GAP_V = DUR_W'(GAP_MS);

  function automatic logic [HW-1:0] half_of(input logic [7:0] note);
    logic [HW-1:0] h;
    h = '0;
    for (int o = 0; o < NUM_OCTAVES; o++)
      for (int s = 0; s < 12; s++)
        if (int'(note) == 1 + 12 * o + s) h = HW'(BASE[s] >> o);
    return h;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_mem_note [FIFO_DEPTH];
  logic [DUR_W-1:0]  r_mem_dur  [FIFO_DEPTH];
  logic [AW-1:0]     r_wr, r_rd;
  logic [CW-1:0]     r_count, w_count_nxt;
  logic [PW-1:0]     r_pre;
  logic [DUR_W-1:0]  r_ms_left;
  logic [HW-1:0]     r_hcnt, r_half;
  logic              r_rest, r_spk, r_done;
  logic              w_full, w_push, w_pop, w_tick, w_last, w_half_hit, w_head_rest;
  logic [7:0]        w_head_note;
  logic [DUR_W-1:0]  w_head_dur;

  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign CMD_READY   = RST_N && !w_full && !STOP;
  assign w_push      = CMD_VALID && CMD_READY;
  assign w_pop       = (r_state == S_LOAD) && (r_count != '0) && !STOP;
  assign w_count_nxt = STOP ? '0 : r_count + CW'(w_push) - CW'(w_pop);
  assign w_head_note = r_mem_note[r_rd];
  assign w_head_dur  = r_mem_dur[r_rd];
  assign w_head_rest = (w_head_note == 8'd0) || (int'(w_head_note) > MAXN);
  assign w_tick      = (r_pre == PW'(MS - 1));
  assign w_last      = w_tick && (r_ms_left == DUR_W'(1));
  assign w_half_hit  = (r_hcnt == r_half - HW'(1));

  assign SPEAKER    = r_spk;
  assign NOTE_DONE  = r_done;
  assign FIFO_COUNT = r_count;
  assign BUSY       = (r_count != '0) || (r_state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem_note[r_wr] <= NOTE;
      r_mem_dur[r_wr]  <= DUR_MS;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (STOP) begin
        r_wr <= '0;
        r_rd <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + AW'(1);
        if (w_pop)  r_rd <= r_rd + AW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A zero-length entry is dropped in LOAD and the next one is fetched directly.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (r_count != '0) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (w_head_dur == '0) w_state_nxt = (w_count_nxt != '0) ? S_LOAD : S_IDLE;
        else                  w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        if (w_last) begin
          if (GAP_MS != 0) w_state_nxt = S_GAP;
          else             w_state_nxt = (r_count != '0) ? S_LOAD : S_IDLE;
        end
      end
      S_GAP:   if (w_last) w_state_nxt = (r_count != '0) ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (STOP) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (r_state == S_LOAD) begin
      r_half <= half_of(w_head_note);
      r_rest <= w_head_rest;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pre     <= '0;
      r_ms_left <= '0;
      r_hcnt    <= '0;
      r_spk     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (STOP) begin
        r_pre     <= '0;
        r_ms_left <= '0;
        r_hcnt    <= '0;
        r_spk     <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            r_pre     <= '0;
            r_hcnt    <= '0;
            r_spk     <= 1'b0;
            r_ms_left <= w_head_dur;
          end
          S_PLAY: begin
            if (w_last) begin
              r_done    <= 1'b1;
              r_spk     <= 1'b0;
              r_pre     <= '0;
              r_hcnt    <= '0;
              r_ms_left <= GAP_V;
            end else begin
              if (w_tick) begin
                r_pre     <= '0;
                r_ms_left <= r_ms_left - DUR_W'(1);
              end else begin
                r_pre <= r_pre + PW'(1);
              end
              // Rests run the same counters but keep the output low.
              if (w_half_hit) begin
                r_hcnt <= '0;
                r_spk  <= ~r_spk & ~r_rest;
              end else begin
                r_hcnt <= r_hcnt + HW'(1);
              end
            end
          end
          S_GAP: begin
            r_spk <= 1'b0;
            if (w_tick) begin
              r_pre     <= '0;
              r_ms_left <= r_ms_left - DUR_W'(1);
            end else begin
              r_pre <= r_pre + PW'(1);
            end
          end
          default: r_spk <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer at a scaled-down clock (100 clocks per ms).
module tb_tone_sequencer;

  localparam int CLK_HZ      = 100_000;
  localparam int NUM_OCTAVES = 4;
  localparam int FIFO_DEPTH  = 8;
  localparam int DUR_W       = 16;
  localparam int GAP_MS      = 1;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [7:0]       NOTE;
  logic [DUR_W-1:0] DUR_MS;
  logic             STOP;
  logic             SPEAKER;
  logic             BUSY;
  logic             NOTE_DONE;
  logic [3:0]       FIFO_COUNT;

  int n_cmp  = 0;
  int n_fail = 0;

  tone_sequencer #(
    .CLK_HZ(CLK_HZ), .NUM_OCTAVES(NUM_OCTAVES), .FIFO_DEPTH(FIFO_DEPTH),
    .DUR_W(DUR_W), .GAP_MS(GAP_MS)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .NOTE(NOTE), .DUR_MS(DUR_MS), .STOP(STOP), .SPEAKER(SPEAKER), .BUSY(BUSY),
    .NOTE_DONE(NOTE_DONE), .FIFO_COUNT(FIFO_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // first_rise = 2 + HALF (0: never rises); done_at/idle_at in cycles after accept.
  typedef struct {
    string      tag;
    logic [7:0] note;
    int         dur;
    int         first_rise;
    int         rises;
    int         done_at;
    int         idle_at;
  } vec_t;

  task automatic push(input logic [7:0] note, input int dur);
    @(negedge CLK);
    NOTE      = note;
    DUR_MS    = DUR_W'(dur);
    CMD_VALID = 1'b1;
    @(posedge CLK);
  endtask

  task automatic play_one(input logic [7:0] note, input int dur,
                          output int busy0, output int first_rise, output int rises,
                          output int done_cnt, output int done_at, output int idle_at,
                          output int bad_iv);
    int   rel, last_t, half;
    logic prev;
    push(note, dur);
    @(negedge CLK);
    CMD_VALID  = 1'b0;
    busy0      = int'(BUSY);
    rel        = 0;
    first_rise = 0;
    rises      = 0;
    done_cnt   = 0;
    done_at    = 0;
    idle_at    = 0;
    bad_iv     = 0;
    last_t     = -1;
    half       = 0;
    prev       = SPEAKER;
    while (idle_at == 0 && rel < 3000) begin
      @(posedge CLK);
      rel++;
      @(negedge CLK);
      if (SPEAKER != prev && !NOTE_DONE) begin
        if (last_t < 0) half = rel - 2;
        else if (rel - last_t != half) bad_iv++;
        last_t = rel;
        if (SPEAKER) begin
          rises++;
          if (first_rise == 0) first_rise = rel;
        end
      end
      if (NOTE_DONE) begin
        done_cnt++;
        if (done_at == 0) done_at = rel;
      end
      if (!BUSY) idle_at = rel;
      prev = SPEAKER;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [9];
    int   busy0, fr, rs, dc, da, ia, bi, rel, d1, d2, spk_hi, seen, min_cnt;

    vecs[0] = '{"c5_d1",   8'h01, 1, 98, 1,  102, 202};
    vecs[1] = '{"c5_d3",   8'h01, 3, 98, 2,  302, 402};
    vecs[2] = '{"b8_d2",   8'h30, 2, 8,  17, 202, 302};
    vecs[3] = '{"c6_d1",   8'h0D, 1, 50, 1,  102, 202};
    vecs[4] = '{"a5_d1",   8'h0A, 1, 59, 1,  102, 202};
    vecs[5] = '{"c8_d1",   8'h25, 1, 14, 4,  102, 202};
    vecs[6] = '{"rest0",   8'h00, 1, 0,  0,  102, 202};
    vecs[7] = '{"rest49",  8'h31, 1, 0,  0,  102, 202};
    vecs[8] = '{"dur0",    8'h05, 0, 0,  0,  0,   2};

    // Reset with a command pending on the input
    RST_N = 1'b0; CMD_VALID = 1'b1; NOTE = 8'h01; DUR_MS = 16'd1; STOP = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ready",   int'(CMD_READY), 0);
    check("rst_speaker", int'(SPEAKER), 0);
    check("rst_busy",    int'(BUSY), 0);
    check("rst_done",    int'(NOTE_DONE), 0);
    check("rst_count",   int'(FIFO_COUNT), 0);
    CMD_VALID = 1'b0;
    RST_N     = 1'b1;
    #1;
    check("post_rst_ready", int'(CMD_READY), 1);
    @(posedge CLK);
    @(negedge CLK);
    check("post_rst_count", int'(FIFO_COUNT), 0);
    check("post_rst_busy",  int'(BUSY), 0);

    for (int i = 0; i < 9; i++) begin
      play_one(vecs[i].note, vecs[i].dur, busy0, fr, rs, dc, da, ia, bi);
      check({vecs[i].tag, "_busy_after_accept"}, busy0, 1);
      check({vecs[i].tag, "_first_rise"}, fr, vecs[i].first_rise);
      check({vecs[i].tag, "_rises"}, rs, vecs[i].rises);
      check({vecs[i].tag, "_done_pulses"}, dc, (vecs[i].done_at != 0) ? 1 : 0);
      check({vecs[i].tag, "_done_at"}, da, vecs[i].done_at);
      check({vecs[i].tag, "_idle_at"}, ia, vecs[i].idle_at);
      check({vecs[i].tag, "_bad_intervals"}, bi, 0);
      repeat (3) @(posedge CLK);
    end

    // Two queued notes: B8 for 2 ms then a 1 ms rest, 1 ms gap between
    push(8'h30, 2);
    push(8'h00, 1);
    @(negedge CLK);
    CMD_VALID = 1'b0;
    rel = 1; d1 = 0; d2 = 0; spk_hi = 0; ia = 0; dc = 0;
    while (ia == 0 && rel < 2000) begin
      @(posedge CLK);
      rel++;
      @(negedge CLK);
      if (NOTE_DONE) begin
        dc++;
        if (d1 == 0) d1 = rel; else d2 = rel;
      end
      if (d1 != 0 && SPEAKER) spk_hi++;
      if (!BUSY) ia = rel;
    end
    check("seq_done_pulses", dc, 2);
    check("seq_done1_at", d1, 202);
    check("seq_done_spacing", d2 - d1, 201);
    check("seq_rest_silent", spk_hi, 0);
    check("seq_idle_at", ia, 503);
    repeat (3) @(posedge CLK);

    // Fill the FIFO while the first note is playing; the 9th must be held
    push(8'h01, 5);
    @(negedge CLK);
    CMD_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    for (int i = 0; i < 8; i++) push(8'h02, 1);
    @(negedge CLK);
    NOTE = 8'h03;
    check("full_count", int'(FIFO_COUNT), 8);
    check("full_ready", int'(CMD_READY), 0);
    seen = 0; min_cnt = 8; rel = 0;
    while (!CMD_READY && rel < 1500) begin
      @(posedge CLK);
      rel++;
      @(negedge CLK);
      if (int'(FIFO_COUNT) < min_cnt) min_cnt = int'(FIFO_COUNT);
    end
    check("held_ready_seen", int'(CMD_READY), 1);
    check("held_count_before_accept", int'(FIFO_COUNT), 7);
    @(posedge CLK);
    @(negedge CLK);
    CMD_VALID = 1'b0;
    check("held_accepted_count", int'(FIFO_COUNT), 8);
    check("held_min_count", min_cnt, 7);
    STOP = 1'b1;
    #1;
    check("stop_ready_low", int'(CMD_READY), 0);
    @(posedge CLK);
    @(negedge CLK);
    STOP = 1'b0;
    check("flush_count", int'(FIFO_COUNT), 0);
    check("flush_busy", int'(BUSY), 0);
    repeat (3) @(posedge CLK);

    // Three notes pushed back-to-back (third push meets the first pop), STOP mid second note
    push(8'h01, 1);
    push(8'h01, 1);
    push(8'h01, 1);
    @(negedge CLK);
    CMD_VALID = 1'b0;
    check("push_pop_same_cycle_count", int'(FIFO_COUNT), 2);
    dc = 0; rel = 0;
    while (!(FIFO_COUNT == 4'd1 && SPEAKER) && rel < 1000) begin
      @(posedge CLK);
      rel++;
      @(negedge CLK);
      if (NOTE_DONE) dc++;
    end
    check("second_note_sounding", int'(SPEAKER), 1);
    check("first_note_done", dc, 1);
    STOP = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    STOP = 1'b0;
    check("stop_speaker", int'(SPEAKER), 0);
    check("stop_count", int'(FIFO_COUNT), 0);
    check("stop_busy", int'(BUSY), 0);
    check("stop_done", int'(NOTE_DONE), 0);
    dc = 0; seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (NOTE_DONE) dc++;
      if (BUSY || SPEAKER) seen++;
    end
    check("after_stop_no_done", dc, 0);
    check("after_stop_quiet", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
